spi_slave: RTL
==============

# spi_slave

SPI responder (mode 0: CPOL=0, CPHA=0, MSB first) that drives the `Slave` side of the team's `spi_interface` with `CS_COUNT = 1`. It oversamples SCK, MOSI and CS in the system clock domain and shifts words in and out. Parallel data reaches user logic through a one-entry transmit holding register with a valid/ready handshake, and through a one-cycle receive strobe. It is the counterpart to the SPI master on the same bus and is the peripheral front end for register-mapped SPI targets.

## Interface
- `DATA_WIDTH`, default 8: bits per SPI word.
- `SYNC_STAGES`, default 3: flip-flop stages on each of SCK, MOSI and CS; minimum 2.
- `clk` input, 1: system clock; all logic is on its rising edge.
- `reset_n` input, 1: asynchronous, active-low reset.
- `spi` `spi_interface.Slave`, –: bus port.
  - `cs[0]` is an active-low select.
  - `miso` is driven by this block.
  - `sck` and `mosi` are inputs.
- `tx_data` input, DATA_WIDTH: word to send next.
- `tx_valid` input, 1: `tx_data` is valid.
- `tx_ready` output, 1: the holding register is empty; a word is accepted when `tx_valid && tx_ready`.
- `rx_data` output, DATA_WIDTH: last received word; holds until the next word completes.
- `rx_valid` output, 1: one-cycle strobe when `rx_data` updates. There is no backpressure.
- `tx_underrun` output, 1: one-cycle strobe when a word load finds the holding register empty; all-zero data is sent instead.
- `busy` output, 1: high while the block is selected (state ACTIVE).

## Operation
- **Synchronisers:** SCK, MOSI and CS each pass through SYNC_STAGES flops. Edges are detected by comparing the last sync stage with one extra delay flop.
- **States:** IDLE and ACTIVE.
  - IDLE → ACTIVE on a synchronised CS falling edge.
  - ACTIVE → IDLE on a synchronised CS rising edge, from any bit position.
- **Word load:** copies the holding register into `tx_shift` and empties the register. If the register is empty, `tx_shift` loads 0 and `tx_underrun` pulses.
  - A load happens on CS-fall detection.
  - A load also happens on every SCK falling edge that follows a completed word (`bit_cnt == 0` in ACTIVE).
- **SCK rising edge (ACTIVE):**
  - `rx_shift` becomes `{rx_shift[W-2:0], mosi_sync}`.
  - `bit_cnt` increments modulo DATA_WIDTH.
  - On wrap to 0, `rx_data` takes the assembled word and `rx_valid` pulses the following cycle.
- **SCK falling edge (ACTIVE):** if `bit_cnt != 0`, `tx_shift` shifts left by one; otherwise a word load occurs.
- **MISO:** `miso = tx_shift[W-1]` while in ACTIVE, and 0 in IDLE.
- **Abort:** a CS rising edge mid-word returns to IDLE with `bit_cnt = 0`.
  - No `rx_valid` is produced and the partial word is discarded.
  - The holding register is untouched; a word already loaded into `tx_shift` is lost.
- **Handshake:**
  - `tx_ready = !hold_full`.
  - If a load and `tx_valid` occur in the same cycle with the register empty, the load underruns (no bypass) and the offered word is captured for the next load.
  - If the register is full on that cycle, no accept is possible and `tx_ready` rises the cycle after the load.
- SCK edges while in IDLE are ignored.

## Timing
- **Reset values:** state IDLE; `miso`, `rx_data`, `rx_valid`, `tx_underrun`, `busy`, `bit_cnt`, the shifters and `hold_full` are all 0; `tx_ready` is 1.
- **Input latency:** a pin change is seen SYNC_STAGES+1 clk cycles later (4 with defaults).
- **`rx_valid` latency:** asserts 5 cycles after the last SCK rising pin edge of a word (defaults).
- **MISO latency:** updates 4 cycles after an SCK falling pin edge, and 4 cycles after the CS falling pin edge for the first bit.
- **Bus constraints:**
  - SCK high and low phases ≥ SYNC_STAGES+3 clk cycles each, giving f_sck ≤ f_clk/12 with defaults.
  - CS fall to first SCK rise ≥ SYNC_STAGES+3 clk cycles.
- **Refill deadline:** to avoid underrun, the next word must be accepted before the synchronised SCK falling edge that follows bit DATA_WIDTH-1.

## Test plan
- **Single byte:** queue `tx_data = 0xA5`, then run one 8-bit master frame with MOSI = 0x3C. Required: master reads 0xA5, `rx_data = 0x3C`, exactly one `rx_valid` pulse, `tx_ready` returns to 1, no `tx_underrun`.
- **Back-to-back words:** send 0x11, then refill 0x22 during bit 3 of the first word, in one 16-clock frame with MOSI 0xDE, 0xAD. Required: MISO carries 0x11 then 0x22; `rx_valid` pulses twice with 0xDE then 0xAD.
- **Underrun:** open a frame with nothing queued. Required: `tx_underrun` pulses at CS fall, MISO reads 0x00, and rx still completes normally.
- **Abort:** deassert CS after 5 SCK cycles, then run a new full frame with MOSI 0x81. Required:
  - No `rx_valid` for the aborted word.
  - The new frame gives `rx_data = 0x81` with bit alignment from bit 7.
- **Reset mid-frame:** pull `reset_n` low after 3 bits, then release. Required: every output is at its reset value while `reset_n` is low, and the next full frame works correctly.
- **Simultaneous load and offer:** present `tx_valid` in the same cycle as the CS-fall load with the register empty. Required: underrun pulse, and the offered word goes out as the second word of the frame.

Source files
------------

// File: rtl/spi_slave_if.sv
// -----------------------------------------------------------------------------
// spi_interface
//   Shared SPI bus bundle: one serial clock, MOSI/MISO data lines and
//   CS_COUNT active-low chip selects.
//   Modports:
//     Master : drives sck, mosi and cs; samples miso
//     Slave  : samples sck, mosi and cs; drives miso
// -----------------------------------------------------------------------------
interface spi_interface #(
  parameter int CS_COUNT = 1
);
  logic                sck;
  logic                mosi;
  logic                miso;
  logic [CS_COUNT-1:0] cs;

  modport Master (output sck, output mosi, output cs, input miso);
  modport Slave  (input sck, input mosi, input cs, output miso);
endinterface

// File: rtl/spi_slave.sv
// -----------------------------------------------------------------------------
// spi_slave
//   SPI mode-0 responder (CPOL=0, CPHA=0, MSB first). SCK, MOSI and CS are
//   oversampled in the clk domain. Each word is shifted in on synchronised SCK
//   rising edges and shifted out on synchronised SCK falling edges. A
//   one-entry holding register feeds the transmitter.
//
//   Ports:
//     clk         system clock, all logic on its rising edge
//     reset_n     asynchronous active-low reset
//     spi         bus port (cs[0] active-low select, miso driven here)
//     tx_data     word to send next
//     tx_valid    tx_data is valid
//     tx_ready    holding register empty; accept on tx_valid && tx_ready
//     rx_data     last received word, held until the next word completes
//     rx_valid    one-cycle strobe, one cycle after rx_data updates
//     tx_underrun one-cycle strobe when a word load finds the register empty
//     busy        high while selected
//
//   DATA_WIDTH must be at least 2 and SYNC_STAGES at least 2.
// -----------------------------------------------------------------------------
module spi_slave #(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 3
) (
  input  logic                  clk,
  input  logic                  reset_n,
  spi_interface.Slave           spi,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  tx_underrun,
  output logic                  busy
);

  localparam int             CNT_W    = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

  // ---------------------------------------------------------------------------
  // Input synchronisers and edge detection
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] r_sck_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic [SYNC_STAGES-1:0] r_cs_sync;
  logic                   r_sck_d;
  logic                   r_cs_d;

  // CS resets to its deselected (high) level so leaving reset never looks
  // like a select edge.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sck_sync  <= '0;
      r_mosi_sync <= '0;
      r_cs_sync   <= '1;
      r_sck_d     <= 1'b0;
      r_cs_d      <= 1'b1;
    end else begin
      r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], spi.sck};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi.mosi};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], spi.cs[0]};
      r_sck_d     <= r_sck_sync[SYNC_STAGES-1];
      r_cs_d      <= r_cs_sync[SYNC_STAGES-1];
    end
  end

  logic w_sck;
  logic w_mosi;
  logic w_cs;
  logic w_sck_rise;
  logic w_sck_fall;
  logic w_cs_fall;
  logic w_cs_rise;

  assign w_sck      = r_sck_sync[SYNC_STAGES-1];
  assign w_mosi     = r_mosi_sync[SYNC_STAGES-1];
  assign w_cs       = r_cs_sync[SYNC_STAGES-1];
  assign w_sck_rise =  w_sck & ~r_sck_d;
  assign w_sck_fall = ~w_sck &  r_sck_d;
  assign w_cs_fall  = ~w_cs  &  r_cs_d;
  assign w_cs_rise  =  w_cs  & ~r_cs_d;

  // ---------------------------------------------------------------------------
  // FSM: state register / next state / outputs
  // ---------------------------------------------------------------------------
  state_t r_state;
  state_t w_state_next;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_next;
  end

  // NOTE: the default assignment before the case keeps every path assigned,
  // so no latch is inferred.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:   if (w_cs_fall) w_state_next = ST_ACTIVE;
      ST_ACTIVE: if (w_cs_rise) w_state_next = ST_IDLE;
      default:   w_state_next = ST_IDLE;
    endcase
  end

  logic [DATA_WIDTH-1:0] r_tx_shift;
  logic                  w_busy;
  logic                  w_miso;

  always_comb begin
    w_busy = 1'b0;
    w_miso = 1'b0;
    if (r_state == ST_ACTIVE) begin
      w_busy = 1'b1;
      w_miso = r_tx_shift[DATA_WIDTH-1];
    end
  end

  assign busy     = w_busy;
  assign spi.miso = w_miso;

  // ---------------------------------------------------------------------------
  // Datapath control
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0]      r_bit_cnt;
  logic [DATA_WIDTH-1:0] r_rx_shift;
  logic [DATA_WIDTH-1:0] r_rx_data;
  logic                  r_rx_done;
  logic                  r_rx_valid;
  logic                  r_tx_underrun;
  logic [DATA_WIDTH-1:0] r_hold_data;
  logic                  r_hold_full;

  logic w_active;
  logic w_sck_rise_act;
  logic w_sck_fall_act;
  logic w_word_done;
  logic w_load;
  logic w_accept;

  // A deselect wins over an SCK edge seen in the same cycle, so a master that
  // drops SCK and raises CS together ends the frame without a trailing load.
  assign w_active       = (r_state == ST_ACTIVE);
  assign w_sck_rise_act = w_active && !w_cs_rise && w_sck_rise;
  assign w_sck_fall_act = w_active && !w_cs_rise && w_sck_fall;
  assign w_word_done    = w_sck_rise_act && (r_bit_cnt == LAST_BIT);
  assign w_load         = (!w_active && w_cs_fall) ||
                          (w_sck_fall_act && (r_bit_cnt == '0));
  assign w_accept       = tx_valid && !r_hold_full;

  // ---------------------------------------------------------------------------
  // Receive path
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_bit_cnt  <= '0;
      r_rx_shift <= '0;
      r_rx_data  <= '0;
      r_rx_done  <= 1'b0;
      r_rx_valid <= 1'b0;
    end else begin
      r_rx_done  <= w_word_done;
      r_rx_valid <= r_rx_done;
      if (w_active && w_cs_rise) begin
        // Abort or normal end: drop any partial word alignment.
        r_bit_cnt <= '0;
      end else if (w_sck_rise_act) begin
        r_rx_shift <= {r_rx_shift[DATA_WIDTH-2:0], w_mosi};
        if (w_word_done) begin
          r_bit_cnt <= '0;
          r_rx_data <= {r_rx_shift[DATA_WIDTH-2:0], w_mosi};
        end else begin
          r_bit_cnt <= r_bit_cnt + 1'b1;
        end
      end
    end
  end

  assign rx_data  = r_rx_data;
  assign rx_valid = r_rx_valid;

  // ---------------------------------------------------------------------------
  // Transmit path and holding register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tx_shift    <= '0;
      r_tx_underrun <= 1'b0;
      r_hold_data   <= '0;
      r_hold_full   <= 1'b0;
    end else begin
      r_tx_underrun <= w_load && !r_hold_full;

      if (w_load)              r_tx_shift <= r_hold_full ? r_hold_data : '0;
      else if (w_sck_fall_act) r_tx_shift <= {r_tx_shift[DATA_WIDTH-2:0], 1'b0};

      // A load empties the register; an offer in the same cycle can only be
      // taken if it was already empty, and then it refills it (no bypass).
      if (w_load)        r_hold_full <= w_accept;
      else if (w_accept) r_hold_full <= 1'b1;

      if (w_accept) r_hold_data <= tx_data;
    end
  end

  assign tx_ready    = !r_hold_full;
  assign tx_underrun = r_tx_underrun;

endmodule
